// File: rtl/imm_encoder.sv
// imm_encoder
//   Packs a 32-bit I- or S-type immediate into instruction bits [31:7]
//   (a 25-bit field), keeping the caller's rs1/rs2/funct3/rd bits. This is
//   the inverse of the zero-extending immediate generator. Results pass
//   through a small FIFO with valid/ready handshakes on both sides. Accepted
//   requests are counted as in-range or out-of-range.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     request handshake
//   in_imm                immediate to encode
//   in_src                0 = I-type, 1 = S-type
//   in_base               instruction bits [31:7]; immediate positions ignored
//   out_valid/out_ready   result handshake
//   out_inm, out_err      head entry: packed field and out-of-range flag
//   cnt_ok, cnt_err       saturating counts of accepted requests
module imm_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_imm,
    input  logic             in_src,
    input  logic [24:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      out_inm,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [24:0] inm;
        logic        err;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_ok_q, cnt_ok_d, cnt_err_q, cnt_err_d;

    logic        full, empty, push, pop;
    logic        pk_err;
    logic [11:0] pk_imm;
    logic [24:0] pk_inm;

    // The generator zero-extends, so any bit above 11 makes the value
    // unrepresentable; the immediate positions are then packed as zero.
    always_comb begin
        pk_err = |in_imm[31:12];
        pk_imm = pk_err ? 12'h000 : in_imm[11:0];
        if (!in_src)
            pk_inm = {pk_imm, in_base[12:0]};
        else
            pk_inm = {pk_imm[11:5], in_base[17:5], pk_imm[4:0]};
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = out_ready && !empty;

    // Output is forced to zero while empty so reset shows a clean field.
    assign out_inm = empty ? 25'h0 : mem_q[rd_q[AW-1:0]].inm;
    assign out_err = empty ? 1'b0  : mem_q[rd_q[AW-1:0]].err;
    assign cnt_ok  = cnt_ok_q;
    assign cnt_err = cnt_err_q;

    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        cnt_ok_d  = cnt_ok_q;
        cnt_err_d = cnt_err_q;
        if (push) begin
            wr_d = wr_q + (AW+1)'(1);
            if (pk_err) begin
                if (!(&cnt_err_q)) cnt_err_d = cnt_err_q + CNT_W'(1);
            end else begin
                if (!(&cnt_ok_q)) cnt_ok_d = cnt_ok_q + CNT_W'(1);
            end
        end
        if (pop) rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_ok_q  <= '0;
            cnt_err_q <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_ok_q  <= cnt_ok_d;
            cnt_err_q <= cnt_err_d;
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= '{inm: pk_inm, err: pk_err};
    end
endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, in_src;
    logic [31:0] in_imm;
    logic [24:0] in_base;
    logic        in_ready, out_valid, out_err;
    logic [24:0] out_inm;
    logic [15:0] cnt_ok, cnt_err;
    logic        in_ready4, out_valid4, out_err4;
    logic [24:0] out_inm4;
    logic [3:0]  cnt_ok4, cnt_err4;

    always #5 clk = ~clk;

    imm_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_src(in_src), .in_base(in_base),
        .out_valid(out_valid), .out_ready(out_ready), .out_inm(out_inm),
        .out_err(out_err), .cnt_ok(cnt_ok), .cnt_err(cnt_err));

    // Same stimulus, narrow counters to exercise saturation.
    imm_encoder #(.DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_imm(in_imm), .in_src(in_src), .in_base(in_base),
        .out_valid(out_valid4), .out_ready(out_ready), .out_inm(out_inm4),
        .out_err(out_err4), .cnt_ok(cnt_ok4), .cnt_err(cnt_err4));

    int total = 0, bad = 0;

    typedef struct {
        logic [24:0] inm;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] imm;
        logic        src;
        logic [24:0] base;
        logic [24:0] inm;
        logic        err;
    } vec_t;

    exp_t q[$];
    int   m_ok = 0, m_err = 0;

    // Reference: field built with arithmetic from the bit-position rules.
    function automatic exp_t model(logic [31:0] imm, logic src, logic [24:0] base);
        exp_t        e;
        int unsigned v, b;
        e.err = (imm > 32'd4095);
        v = e.err ? 0 : imm;
        b = base;
        if (!src) e.inm = 25'((v * 8192) + (b % 8192));
        else      e.inm = 25'(((v / 32) * 262144) + (v % 32) + ((b / 32) % 8192) * 32);
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_state(string tag);
        int c4ok, c4err;
        c4ok  = (m_ok  > 15) ? 15 : m_ok;
        c4err = (m_err > 15) ? 15 : m_err;
        chk({tag, " out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, " in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
        if (q.size() > 0) begin
            chk({tag, " out_inm"}, 32'(out_inm), 32'(q[0].inm));
            chk({tag, " out_err"}, 32'(out_err), 32'(q[0].err));
            chk({tag, " out_inm4"}, 32'(out_inm4), 32'(q[0].inm));
        end
        chk({tag, " cnt_ok"},   32'(cnt_ok),   32'(m_ok));
        chk({tag, " cnt_err"},  32'(cnt_err),  32'(m_err));
        chk({tag, " cnt_ok4"},  32'(cnt_ok4),  32'(c4ok));
        chk({tag, " cnt_err4"}, 32'(cnt_err4), 32'(c4err));
    endtask

    // One clock: model decides accept/pop from its own occupancy.
    task automatic tick();
        bit   acc, pop;
        exp_t e;
        acc = in_valid && (q.size() < DEPTH);
        pop = out_ready && (q.size() > 0);
        e   = model(in_imm, in_src, in_base);
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(e);
            if (e.err) m_err++; else m_ok++;
        end
    endtask

    task automatic drive(logic v, logic [31:0] imm, logic src, logic [24:0] base);
        in_valid = v; in_imm = imm; in_src = src; in_base = base;
    endtask

    task automatic model_reset();
        q.delete();
        m_ok = 0;
        m_err = 0;
    endtask

    vec_t tbl[5];

    initial begin
        logic [11:0] dec;
        rst = 1'b1; out_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 25'h0);
        @(posedge clk); #1;
        // reset state
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_inm",   32'(out_inm),   32'd0);
        chk("rst out_err",   32'(out_err),   32'd0);
        chk("rst cnt_ok",    32'(cnt_ok),    32'd0);
        chk("rst cnt_err",   32'(cnt_err),   32'd0);
        rst = 1'b0;
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);

        // directed vectors: expected fields worked out by hand
        tbl[0] = '{32'h0000_0ABC, 1'b0, 25'h0000155, 25'h1578155, 1'b0};
        tbl[1] = '{32'h0000_0ABC, 1'b1, 25'h0000000, 25'h154001C, 1'b0};
        tbl[2] = '{32'h0000_1000, 1'b0, 25'h1FFFFFF, 25'h0001FFF, 1'b1};
        tbl[3] = '{32'hFFFF_F800, 1'b1, 25'h1FFFFFF, 25'h003FFE0, 1'b1};
        tbl[4] = '{32'h0000_0FFF, 1'b0, 25'h0000000, 25'h1FFE000, 1'b0};
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            drive(1'b1, tbl[i].imm, tbl[i].src, tbl[i].base);
            check_state("tbl pre");
            tick();
            drive(1'b0, 32'h0, 1'b0, 25'h0);
            chk("tbl latency valid", 32'(out_valid), 32'd1);
            chk("tbl inm", 32'(out_inm), 32'(tbl[i].inm));
            chk("tbl err", 32'(out_err), 32'(tbl[i].err));
            if (!tbl[i].err) begin
                dec = tbl[i].src ? {out_inm[24:18], out_inm[4:0]} : out_inm[24:13];
                chk("tbl roundtrip", 32'(dec), tbl[i].imm);
            end
            check_state("tbl post");
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check_state("tbl drained");
        end
        chk("tbl cnt_ok total",  32'(cnt_ok),  32'd3);
        chk("tbl cnt_err total", 32'(cnt_err), 32'd2);

        // backpressure: A and B fill the FIFO, C is held until a pop frees space
        out_ready = 1'b0;
        drive(1'b1, 32'h1, 1'b0, 25'h0);
        tick();
        drive(1'b1, 32'h2, 1'b1, 25'h0);
        tick();
        chk("bp full in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h7FF, 1'b0, 25'h1ABCDE);
        check_state("bp full");
        tick();
        check_state("bp held");
        out_ready = 1'b1;
        tick();
        chk("bp in_ready after pop", 32'(in_ready), 32'd1);
        chk("bp head B", 32'(out_inm), 32'(model(32'h2, 1'b1, 25'h0).inm));
        check_state("bp pop1");
        tick();
        drive(1'b0, 32'h0, 1'b0, 25'h0);
        chk("bp head C", 32'(out_inm), 32'(model(32'h7FF, 1'b0, 25'h1ABCDE).inm));
        check_state("bp pop2");
        tick();
        check_state("bp empty");

        // saturation of the 4-bit counters
        rst = 1'b1; #1; model_reset(); rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'(i * 100), 1'(i % 2), 25'(i * 12345));
            tick();
            check_state("sat");
        end
        drive(1'b0, 32'h0, 1'b0, 25'h0);
        chk("sat cnt_ok4",  32'(cnt_ok4), 32'd15);
        chk("sat cnt_ok16", 32'(cnt_ok),  32'd17);

        // reset with two entries buffered
        out_ready = 1'b0;
        drive(1'b1, 32'h123, 1'b0, 25'h0);
        tick();
        drive(1'b1, 32'h456, 1'b1, 25'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 25'h0);
        chk("mid full", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst cnt_ok",    32'(cnt_ok),    32'd0);
        chk("mid rst cnt_err",   32'(cnt_err),   32'd0);
        chk("mid rst out_inm",   32'(out_inm),   32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check_state("mid after");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] imm;
            imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            drive(1'($urandom_range(0, 2) != 0), imm, 1'($urandom), 25'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            check_state("rnd");
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 25'h0);
        check_state("rnd end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
